// File: rtl/branch_predictor.sv
// Gshare branch predictor: 2-bit counters indexed by PC ^ global history,
// trained from execute-stage resolutions, with branch/mispredict counters.
module branch_predictor #(
    parameter int unsigned IDX_BITS  = 6,
    parameter int unsigned HIST_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] decode_pc,
    input  logic [31:0] decode_inst,
    output logic        predict,
    input  logic        pred_en,
    input  logic        result,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned ENTRIES      = 1 << IDX_BITS;
    localparam logic [4:0]  OPC_BRANCH_5 = 5'b11000;
    localparam logic [1:0]  CNT_WEAK_NT  = 2'b01;

    logic [1:0]           tbl_q [ENTRIES];
    logic [1:0]           tbl_d [ENTRIES];
    logic [HIST_BITS-1:0] ghr_q, ghr_d;
    logic [IDX_BITS-1:0]  e_idx_q;
    logic                 e_pred_q;
    logic [31:0]          bcnt_q, bcnt_d;
    logic [31:0]          mcnt_q, mcnt_d;

    logic [IDX_BITS-1:0]  d_idx;
    logic [IDX_BITS-1:0]  ghr_ext;
    logic                 is_branch;
    logic [1:0]           cur_cnt;
    logic [1:0]           new_cnt;
    logic                 unused_bits;

    assign unused_bits = ^{decode_pc[31:IDX_BITS+2], decode_pc[1:0],
                           decode_inst[31:7], decode_inst[1:0]};

    assign ghr_ext   = IDX_BITS'(ghr_q);
    assign d_idx     = decode_pc[IDX_BITS+1:2] ^ ghr_ext;
    assign is_branch = (decode_inst[6:2] == OPC_BRANCH_5);

    // Read-before-write: the table is read from registered state only.
    assign predict = is_branch & tbl_q[d_idx][1];

    assign cur_cnt = tbl_q[e_idx_q];

    always_comb begin
        new_cnt = cur_cnt;
        if (result) begin
            if (cur_cnt != 2'b11) new_cnt = cur_cnt + 2'd1;
        end else begin
            if (cur_cnt != 2'b00) new_cnt = cur_cnt - 2'd1;
        end
    end

    generate
        if (HIST_BITS == 1) begin : g_hist1
            always_comb begin
                ghr_d = ghr_q;
                if (pred_en) ghr_d = result;
            end
        end else begin : g_histn
            always_comb begin
                ghr_d = ghr_q;
                if (pred_en) ghr_d = {ghr_q[HIST_BITS-2:0], result};
            end
        end
    endgenerate

    always_comb begin
        tbl_d  = tbl_q;
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (pred_en) begin
            tbl_d[e_idx_q] = new_cnt;
            bcnt_d         = bcnt_q + 32'd1;
            if (e_pred_q != result) mcnt_d = mcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= CNT_WEAK_NT;
            ghr_q    <= '0;
            e_idx_q  <= '0;
            e_pred_q <= 1'b0;
            bcnt_q   <= '0;
            mcnt_q   <= '0;
        end else begin
            tbl_q    <= tbl_d;
            ghr_q    <= ghr_d;
            e_idx_q  <= d_idx;
            e_pred_q <= predict;
            bcnt_q   <= bcnt_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

endmodule
